// File: rtl/ram_param_clear.sv
// ram_param_clear: WIDTH x 2**ADDR_BITS word RAM, Hack-style load/address/out,
// with a one-word-per-cycle clear sweep after reset or on clear_req.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (starts a sweep)
//   in         write data
//   load       write enable (ignored while busy)
//   address    read/write word address
//   clear_req  start a clear sweep (ignored while busy)
//   out        read data (CLEAR_VALUE while busy)
//   busy       high while a sweep runs
//   clear_done one-cycle pulse after the final sweep write
module ram_param_clear #(
    parameter int               WIDTH       = 16,
    parameter int               ADDR_BITS   = 6,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 clear_req,
    output logic [WIDTH-1:0]     out,
    output logic                 busy,
    output logic                 clear_done
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_ptr;
    logic [ADDR_BITS-1:0] w_ptr_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    logic                 w_we;
    logic [ADDR_BITS-1:0] w_waddr;
    logic [WIDTH-1:0]     w_wdata;

    logic [WIDTH-1:0]     r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = address;
        w_wdata     = in;
        unique case (r_state)
            S_CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_ptr;
                w_wdata   = CLEAR_VALUE;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            S_IDLE: begin
                // clear_req has priority: a coincident load is dropped
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end else if (load) begin
                    w_we = 1'b1;
                end
            end
        endcase
    end

    // Storage is deliberately unreset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign busy       = (r_state == S_CLEAR);
    assign out        = busy ? CLEAR_VALUE : r_mem[address];
    assign clear_done = r_done;

endmodule

// File: tb/tb_ram_param_clear.sv
// tb_ram_param_clear: scoreboard bench for ram_param_clear, a 16x64 instance
// and a 1x2 (CLEAR_VALUE=1) instance driven by shared stimulus.
module tb_ram_param_clear;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        clear_req = 1'b0;
    logic [15:0] din = '0;
    logic [5:0]  addr = '0;

    logic [15:0] out_a;
    logic        busy_a;
    logic        done_a;
    logic [0:0]  out_b;
    logic        busy_b;
    logic        done_b;

    always #5 clk = ~clk;

    ram_param_clear #(
        .WIDTH(16),
        .ADDR_BITS(6),
        .CLEAR_VALUE(16'h0000)
    ) dut_a (
        .clk(clk),
        .rst_n(rst_n),
        .in(din),
        .load(load),
        .address(addr),
        .clear_req(clear_req),
        .out(out_a),
        .busy(busy_a),
        .clear_done(done_a)
    );

    ram_param_clear #(
        .WIDTH(1),
        .ADDR_BITS(1),
        .CLEAR_VALUE(1'b1)
    ) dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .in(din[0:0]),
        .load(load),
        .address(addr[0:0]),
        .clear_req(clear_req),
        .out(out_b),
        .busy(busy_b),
        .clear_done(done_b)
    );

    typedef struct {
        int          k;
        logic        busy;
        logic [15:0] out;
        logic        done;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: per-instance contents plus "writes left in sweep".
    logic [15:0] m_mem [2][64];
    int          m_left [2];
    logic        m_done [2];
    int          m_pulses [2] = '{0, 0};
    int          d_pulses [2] = '{0, 0};
    int          busy_cnt [2] = '{0, 0};
    int          depth [2] = '{64, 2};
    logic [15:0] cv [2] = '{16'h0000, 16'h0001};
    logic [15:0] msk [2] = '{16'hFFFF, 16'h0001};

    function automatic int idx(input int k, input logic [5:0] a);
        return (k == 0) ? int'(a) : int'(a[0]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = depth[k];
            m_done[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (m_left[k] > 0) begin
                m_mem[k][depth[k] - m_left[k]] = cv[k];
                m_left[k]--;
                if (m_left[k] == 0) m_done[k] = 1'b1;
            end else if (clear_req) begin
                m_left[k] = depth[k];
            end else if (load) begin
                m_mem[k][idx(k, addr)] = din & msk[k];
            end
        end
    endtask

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    // One clock cycle: drive at negedge, push expectations, update model at posedge.
    task automatic step(input logic r, input logic ld, input logic [5:0] a,
                        input logic [15:0] d, input logic cr);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        load = ld;
        addr = a;
        din = d;
        clear_req = cr;
        if (!r) model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            e.k = k;
            e.busy = (m_left[k] > 0);
            e.out = e.busy ? cv[k] : m_mem[k][idx(k, a)];
            e.done = m_done[k];
            if (e.done) m_pulses[k]++;
            q.push_back(e);
        end
        @(posedge clk);
        if (r) model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 6'(i), 16'h0, 1'b0);
    endtask

    // Monitor: outputs are combinational/registered every cycle, so it
    // samples once per cycle and retires whatever the driver queued.
    initial begin
        exp_t        e;
        logic        ab;
        logic        ad;
        logic [15:0] ao;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.k == 0) begin
                    ab = busy_a;
                    ad = done_a;
                    ao = out_a;
                end else begin
                    ab = busy_b;
                    ad = done_b;
                    ao = {15'b0, out_b};
                end
                if (ab === 1'b1) busy_cnt[e.k]++;
                if (ad === 1'b1) d_pulses[e.k]++;
                checks++;
                if (ab !== e.busy || ad !== e.done || ao !== e.out) begin
                    failures++;
                    $display("FAIL sb k=%0d t=%0t busy=%b/%b done=%b/%b out=%h/%h",
                             e.k, $time, ab, e.busy, ad, e.done, ao, e.out);
                end
            end
        end
    end

    initial begin
        int p0;
        model_reset();

        // reset release: busy edge count and pulse count
        step(1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        busy_cnt = '{0, 0};
        idle(80);
        chk("busy_len_a", busy_cnt[0], 64);
        chk("busy_len_b", busy_cnt[1], 2);
        chk("rst_pulse_a", d_pulses[0], 1);
        chk("rst_pulse_b", d_pulses[1], 1);
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 6'(i), 16'h0, 1'b0);

        // write/read, old value visible during write cycle
        step(1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 6'd5, 16'h0, 1'b0);
        step(1'b1, 1'b0, 6'd6, 16'h0, 1'b0);

        // loads during sweep are ignored
        step(1'b1, 1'b0, 6'd0, 16'h0, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 6'd3, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 6'd3, 16'h0, 1'b0);

        // collision: clear wins over load
        for (int i = 0; i < 64; i++)
            step(1'b1, 1'b1, 6'(i), 16'(i) ^ 16'h5A5A, 1'b0);
        step(1'b1, 1'b1, 6'd10, 16'hFFFF, 1'b1);
        for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 6'(i), 16'h0, 1'b0);

        // reset mid-sweep restarts, only one pulse
        step(1'b1, 1'b0, 6'd0, 16'h0, 1'b1);
        idle(20);
        p0 = d_pulses[0];
        step(1'b0, 1'b0, 6'd0, 16'h0, 1'b0);
        busy_cnt = '{0, 0};
        idle(80);
        chk("mid_rst_busy", busy_cnt[0], 64);
        chk("mid_rst_pulse", d_pulses[0] - p0, 1);

        // clear_req held during narrow sweep: no restart
        p0 = d_pulses[1];
        step(1'b1, 1'b0, 6'd0, 16'h0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 6'd1, 16'h0, 1'b1);
        step(1'b1, 1'b0, 6'd1, 16'h0, 1'b0);
        step(1'b1, 1'b0, 6'd0, 16'h0, 1'b0);
        chk("narrow_pulse", d_pulses[1] - p0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 299) != 0),
                 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)),
                 16'($urandom),
                 ($urandom_range(0, 39) == 0));
        idle(80);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        chk("pulses_a", d_pulses[0], m_pulses[0]);
        chk("pulses_b", d_pulses[1], m_pulses[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
